// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// ALU operation codes and datapath select constants.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_LUI = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b111;

    localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_BRIMM = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_dec.sv
// Combinational opcode/funct to aluop decoder; funct_legal flags supported R-type functs.
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] aluop,
    output logic       funct_legal
);

    logic [ALUOP_W-1:0] r_aluop;

    // R-type funct field mapping
    always_comb begin
        r_aluop     = ALU_ADD;
        funct_legal = 1'b0;
        case (funct)
            FN_ADD: begin r_aluop = ALU_ADD; funct_legal = 1'b1; end
            FN_SUB: begin r_aluop = ALU_SUB; funct_legal = 1'b1; end
            FN_OR:  begin r_aluop = ALU_OR;  funct_legal = 1'b1; end
            FN_SLT: begin r_aluop = ALU_SLT; funct_legal = 1'b1; end
            default: ;
        endcase
    end

    // immediate instructions select by opcode, R-type by funct
    always_comb begin
        aluop = ALU_ADD;
        case (opcode)
            OP_RTYPE: aluop = r_aluop;
            OP_ORI:   aluop = ALU_OR;
            OP_LUI:   aluop = ALU_LUI;
            default:  aluop = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller (Moore FSM). Define MC_CTRL_MEMWAIT_EN to make
// FETCH, MEMRD and MEMWR stall on mem_ready.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [2:0] aluop,
    output logic       illegal,
    output logic       retire,
    output logic [3:0] state
);

    state_t             state_q;
    state_t             state_d;
    logic               pc_write;
    logic               branch;
    logic [ALUOP_W-1:0] dec_aluop;
    logic               funct_legal;
    logic               mem_ok;

`ifdef MC_CTRL_MEMWAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    mips_alu_dec u_alu_dec (
        .opcode      (opcode),
        .funct       (funct),
        .aluop       (dec_aluop),
        .funct_legal (funct_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = PCSRC_ALU;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        imm_zext   = 1'b0;
        aluop      = ALU_ADD;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                if (mem_ok) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_BRIMM;
                case (opcode)
                    OP_LW, OP_SW:          state_d = S_MEMADR;
                    OP_BEQ:                state_d = S_BRANCH;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_IMMEX;
                    OP_J:                  state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_legal) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ok) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                aluop     = dec_aluop;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = ALU_SUB;
                branch    = 1'b1;
                pc_src    = PCSRC_ALUOUT;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aluop     = dec_aluop;
                imm_zext  = (opcode == OP_ORI) || (opcode == OP_LUI);
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // reset holds state at FETCH; suppress every side effect while asserted
        if (rst) begin
            pc_write  = 1'b0;
            branch    = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
            retire    = 1'b0;
        end
    end

    assign pc_en = pc_write | (branch & zero);
    assign state = state_q;

endmodule
